// File: rtl/karnix_io_pkg.sv
// Shared constants and helpers for the Karnix board-I/O front end.
// LED mode encodings and counter-width helpers used by the top and the key debouncer.
package karnix_io_pkg;

    localparam logic [1:0] LED_MODE_GPIO      = 2'b00;
    localparam logic [1:0] LED_MODE_PWM       = 2'b01;
    localparam logic [1:0] LED_MODE_BLINK     = 2'b10;
    localparam logic [1:0] LED_MODE_BLINK_PWM = 2'b11;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/karnix_board_io_if.sv
// Bundle of key/GPIO/LED signals between the SoC side (master) and the board-I/O block (slave).
// Signal names follow the Murax top-level pin names.
interface karnix_board_io_if #(
    parameter int KEYS     = 4,
    parameter int LEDS     = 4,
    parameter int PWM_BITS = 8
);

    logic [KEYS-1:0]          io_key;
    logic [KEYS-1:0]          io_keyState;
    logic [KEYS-1:0]          io_keyPress;
    logic [KEYS-1:0]          io_keyRelease;
    logic [KEYS-1:0]          io_keyPending;
    logic [KEYS-1:0]          io_keyClear;
    logic [LEDS-1:0]          io_gpioWrite;
    logic [LEDS-1:0]          io_gpioWriteEnable;
    logic [2*LEDS-1:0]        io_ledMode;
    logic [PWM_BITS*LEDS-1:0] io_ledDuty;
    logic [LEDS-1:0]          io_led;

    modport master (
        output io_key,
        output io_keyClear,
        output io_gpioWrite,
        output io_gpioWriteEnable,
        output io_ledMode,
        output io_ledDuty,
        input  io_keyState,
        input  io_keyPress,
        input  io_keyRelease,
        input  io_keyPending,
        input  io_led
    );

    modport slave (
        input  io_key,
        input  io_keyClear,
        input  io_gpioWrite,
        input  io_gpioWriteEnable,
        input  io_ledMode,
        input  io_ledDuty,
        output io_keyState,
        output io_keyPress,
        output io_keyRelease,
        output io_keyPending,
        output io_led
    );

endinterface

// File: rtl/karnix_key_debounce.sv
// One push-button: 2-FF synchroniser, stable-count debouncer, registered press/release
// pulses aligned with the state change, and a sticky pending flag.
module karnix_key_debounce
    import karnix_io_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    input  logic clear_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic pending_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = KEY_ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic          level;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          pending_q, pending_d;

    // Normalise so that 1 always means pressed.
    assign level = sync_q[1] ^ IDLE_PIN;

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (level == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d   = level;
            cnt_d     = '0;
            press_d   = level;
            release_d = ~level;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // The visible press pulse sets the flag and beats a simultaneous clear.
        pending_d = press_q | (pending_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= {2{IDLE_PIN}};
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            pending_q <= pending_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/karnix_board_io.sv
// Board-I/O front end: debounced keys with events towards the GPIO port, and
// per-LED selection among GPIO-direct, PWM dimming, blink and dimmed blink.
module karnix_board_io
    import karnix_io_pkg::*;
#(
    parameter int KEYS            = 4,
    parameter int LEDS            = 4,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PWM_BITS        = 8,
    parameter int BLINK_DIV       = 12500000
) (
    input logic               io_mainClk,
    input logic               io_resetn,
    karnix_board_io_if.slave  board
);

    localparam int            BW         = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [KEYS-1:0]     key_state;
    logic [KEYS-1:0]     key_press;
    logic [KEYS-1:0]     key_release;
    logic [KEYS-1:0]     key_pending;

    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [LEDS-1:0]     led_q, led_d;

    generate
        for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
            karnix_key_debounce #(
                .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key (
                .clk_i     (io_mainClk),
                .rst_ni    (io_resetn),
                .key_i     (board.io_key[gi]),
                .clear_i   (board.io_keyClear[gi]),
                .state_o   (key_state[gi]),
                .press_o   (key_press[gi]),
                .release_o (key_release[gi]),
                .pending_o (key_pending[gi])
            );
        end
    endgenerate

    assign board.io_keyState   = key_state;
    assign board.io_keyPress   = key_press;
    assign board.io_keyRelease = key_release;
    assign board.io_keyPending = key_pending;

    // Shared timebase: the PWM counter wraps naturally at its width.
    always_comb begin
        pwm_d         = pwm_q + PWM_BITS'(1);
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    generate
        for (genvar gi = 0; gi < LEDS; gi++) begin : g_led
            logic [PWM_BITS-1:0] duty;
            logic [1:0]          mode;
            logic                pwm_on;
            logic                led_bit;

            assign duty   = board.io_ledDuty[gi*PWM_BITS +: PWM_BITS];
            assign mode   = board.io_ledMode[2*gi +: 2];
            assign pwm_on = (pwm_q < duty);

            always_comb begin
                led_bit = 1'b0;
                case (mode)
                    LED_MODE_GPIO:      led_bit = board.io_gpioWrite[gi] & board.io_gpioWriteEnable[gi];
                    LED_MODE_PWM:       led_bit = pwm_on;
                    LED_MODE_BLINK:     led_bit = blink_phase_q;
                    LED_MODE_BLINK_PWM: led_bit = blink_phase_q & pwm_on;
                    default:            led_bit = 1'b0;
                endcase
            end

            assign led_d[gi] = led_bit;
        end
    endgenerate

    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            pwm_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_q         <= '0;
        end else begin
            pwm_q         <= pwm_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
        end
    end

    assign board.io_led = led_q;

endmodule

// File: tb/tb_karnix_board_io.sv
// Scoreboard bench for karnix_board_io: stimulus queues expected key events and
// output samples by cycle number; a negedge monitor pops and compares them.
module tb_karnix_board_io;
    import karnix_io_pkg::*;

    localparam int KEYS     = 4;
    localparam int LEDS     = 4;
    localparam int PWM_BITS = 4;
    localparam int DEB      = 4;
    localparam int BDIV     = 3;
    localparam int HIST     = 1024;

    localparam int SEL_STATE   = 0;
    localparam int SEL_PENDING = 1;
    localparam int SEL_LED     = 2;
    localparam int SEL_LEDCNT  = 3;
    localparam int SEL_ALL     = 4;

    typedef struct {
        int cyc;
        int key;
        int press;
    } evt_t;

    typedef struct {
        int    cyc;
        int    sel;
        int    idx;
        int    win;
        int    exp;
        string name;
    } chk_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks_total = 0;
    int   checks_passed = 0;

    evt_t            evq[$];
    chk_t            chq[$];
    logic [LEDS-1:0] hist [0:HIST-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    karnix_board_io_if #(.KEYS(KEYS), .LEDS(LEDS), .PWM_BITS(PWM_BITS)) bus ();

    karnix_board_io #(
        .KEYS            (KEYS),
        .LEDS            (LEDS),
        .KEY_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_CYCLES (DEB),
        .PWM_BITS        (PWM_BITS),
        .BLINK_DIV       (BDIV)
    ) dut (
        .io_mainClk (clk),
        .io_resetn  (resetn),
        .board      (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks_total = checks_total + 1;
        if (act == exp) begin
            checks_passed = checks_passed + 1;
            $display("[cyc %0d] ok   %s = %0d", cyc, name, act);
        end else begin
            $display("[cyc %0d] FAIL %s: actual %0d required %0d", cyc, name, act, exp);
        end
    endtask

    function automatic void add_chk(input int c, input int sel, input int idx,
                                    input int win, input int exp, input string name);
        chk_t item;
        int   p;
        item.cyc = c; item.sel = sel; item.idx = idx;
        item.win = win; item.exp = exp; item.name = name;
        p = chq.size();
        while (p > 0 && chq[p-1].cyc > c) p--;
        chq.insert(p, item);
    endfunction

    function automatic void add_evt(input int c, input int key, input int press);
        evt_t item;
        int   p;
        item.cyc = c; item.key = key; item.press = press;
        p = evq.size();
        while (p > 0 && evq[p-1].cyc > c) p--;
        evq.insert(p, item);
    endfunction

    function automatic int sample(input int sel, input int idx, input int win);
        int s;
        s = 0;
        case (sel)
            SEL_STATE:   s = int'(bus.io_keyState[idx]);
            SEL_PENDING: s = int'(bus.io_keyPending[idx]);
            SEL_LED:     s = int'(bus.io_led[idx]);
            SEL_LEDCNT:  for (int j = 0; j < win; j++) s = s + int'(hist[(cyc - j) % HIST][idx]);
            SEL_ALL:     s = int'({bus.io_keyState, bus.io_keyPress, bus.io_keyRelease,
                                   bus.io_keyPending, bus.io_led});
            default:     s = -1;
        endcase
        return s;
    endfunction

    // Monitor: every output cycle, match pulses against the event queue and run due samples.
    initial begin
        int   act, exp;
        logic hit;
        chk_t item;
        forever begin
            @(negedge clk);
            hist[cyc % HIST] = bus.io_led;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                check("event_missing", -1, evq[0].cyc * 100 + evq[0].key * 10 + evq[0].press);
                void'(evq.pop_front());
            end
            for (int k = 0; k < KEYS; k++) begin
                for (int kind = 1; kind >= 0; kind--) begin
                    hit = (kind == 1) ? bus.io_keyPress[k] : bus.io_keyRelease[k];
                    if (hit) begin
                        act = cyc * 100 + k * 10 + kind;
                        exp = -1;
                        if (evq.size() > 0) exp = evq[0].cyc * 100 + evq[0].key * 10 + evq[0].press;
                        check((kind == 1) ? "press_event" : "release_event", act, exp);
                        if (act == exp) void'(evq.pop_front());
                    end
                end
            end
            while (chq.size() > 0 && chq[0].cyc <= cyc) begin
                item = chq.pop_front();
                if (item.cyc < cyc) check({item.name, "_stale"}, cyc, item.cyc);
                else                check(item.name, sample(item.sel, item.idx, item.win), item.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int blink0 [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        int blink1 [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

        bus.io_key             = 4'b0000;
        bus.io_keyClear        = '0;
        bus.io_gpioWrite       = '0;
        bus.io_gpioWriteEnable = '0;
        bus.io_ledMode         = {LED_MODE_GPIO, LED_MODE_GPIO, LED_MODE_GPIO, LED_MODE_GPIO};
        bus.io_ledDuty         = '0;
        resetn                 = 1'b0;

        // Reset held three cycles with every key pressed.
        for (int i = 1; i <= 3; i++) add_chk(i, SEL_ALL, 0, 0, 0, "reset_all_zero");
        tick(3);
        resetn     = 1'b1;
        bus.io_key = 4'b1110;
        add_chk(cyc + 1, SEL_ALL, 0, 0, 0, "first_cycle_after_reset");
        add_evt(cyc + 6, 0, 1);
        add_chk(cyc + 5, SEL_STATE, 0, 0, 0, "key0_state_before");
        add_chk(cyc + 6, SEL_STATE, 0, 0, 1, "key0_state_pressed");
        add_chk(cyc + 7, SEL_PENDING, 0, 0, 1, "key0_pending_set");
        tick(8);
        bus.io_key[0] = 1'b1;
        add_evt(cyc + 6, 0, 0);
        add_chk(cyc + 6, SEL_STATE, 0, 0, 0, "key0_state_released");
        add_chk(cyc + 7, SEL_PENDING, 0, 0, 1, "key0_pending_survives_release");
        tick(8);

        // Glitch of three cycles, one high cycle, then a stable press.
        bus.io_key[1] = 1'b0;
        tick(3);
        bus.io_key[1] = 1'b1;
        tick(1);
        bus.io_key[1] = 1'b0;
        add_chk(cyc + 5, SEL_STATE, 1, 0, 0, "key1_glitch_no_state");
        add_evt(cyc + 6, 1, 1);
        add_chk(cyc + 6, SEL_STATE, 1, 0, 1, "key1_state_pressed");
        tick(10);
        bus.io_key[1] = 1'b1;
        add_evt(cyc + 6, 1, 0);
        tick(8);

        // Pending: clear coinciding with the press pulse loses, a later clear wins.
        bus.io_key[2] = 1'b0;
        add_evt(cyc + 6, 2, 1);
        tick(6);
        bus.io_keyClear[2] = 1'b1;
        add_chk(cyc + 1, SEL_PENDING, 2, 0, 1, "key2_set_beats_clear");
        tick(1);
        bus.io_keyClear[2] = 1'b0;
        tick(1);
        bus.io_keyClear[2] = 1'b1;
        add_chk(cyc, SEL_PENDING, 2, 0, 1, "key2_pending_before_clear");
        add_chk(cyc + 1, SEL_PENDING, 2, 0, 0, "key2_pending_cleared");
        tick(1);
        bus.io_keyClear[2] = 1'b0;
        tick(2);
        bus.io_key[2] = 1'b1;
        add_evt(cyc + 6, 2, 0);
        add_chk(cyc + 7, SEL_PENDING, 2, 0, 0, "key2_release_keeps_clear");
        tick(8);

        // GPIO-direct mode gated by the enable.
        bus.io_gpioWrite = 4'b0001;
        add_chk(cyc + 1, SEL_LED, 0, 0, 0, "gpio_enable_low");
        tick(1);
        bus.io_gpioWriteEnable = 4'b0001;
        add_chk(cyc + 1, SEL_LED, 0, 0, 1, "gpio_enable_high");
        add_chk(cyc + 1, SEL_LED, 1, 0, 0, "gpio_other_led_off");
        tick(1);

        // Reset at debounce count 2; new LED modes are in place when reset releases.
        bus.io_key[3] = 1'b0;
        tick(4);
        resetn         = 1'b0;
        bus.io_key[3]  = 1'b1;
        bus.io_ledMode = {LED_MODE_PWM, LED_MODE_PWM, LED_MODE_BLINK_PWM, LED_MODE_BLINK};
        bus.io_ledDuty = {4'd15, 4'd5, 4'd8, 4'd0};
        add_chk(cyc + 1, SEL_ALL, 0, 0, 0, "mid_debounce_reset_zero");
        add_chk(cyc + 8, SEL_STATE, 3, 0, 0, "key3_aborted");
        tick(1);
        resetn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            add_chk(cyc + n, SEL_LED, 0, 0, blink0[n-1], "blink_led0");
            add_chk(cyc + n, SEL_LED, 1, 0, blink1[n-1], "blink_pwm_led1");
        end
        add_chk(cyc + 13, SEL_LEDCNT, 0, 6, 3, "blink_duty_6");
        add_chk(cyc + 16, SEL_LEDCNT, 2, 16, 5, "pwm_duty5_led2");
        add_chk(cyc + 16, SEL_LEDCNT, 3, 16, 15, "pwm_duty15_led3");
        add_chk(cyc + 48, SEL_LEDCNT, 1, 48, 12, "blink_pwm_count_48");
        tick(50);

        // PWM on LED0 with duty changed on the fly.
        bus.io_ledMode[1:0] = LED_MODE_PWM;
        bus.io_ledDuty[3:0] = 4'd5;
        add_chk(cyc + 17, SEL_LEDCNT, 0, 16, 5, "pwm_duty5_led0");
        tick(18);
        bus.io_ledDuty[3:0] = 4'd0;
        add_chk(cyc + 17, SEL_LEDCNT, 0, 16, 0, "pwm_duty0_led0");
        tick(18);
        bus.io_ledDuty[3:0] = 4'd15;
        add_chk(cyc + 17, SEL_LEDCNT, 0, 16, 15, "pwm_duty15_led0");
        tick(18);

        for (int i = 0; i < 60 && (chq.size() > 0 || evq.size() > 0); i++) tick(1);
        check("queues_drained", chq.size() + evq.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/karnix_board_io.md
Name: karnix_board_io

Overview:
- Parametrised board-I/O front end between the Karnix push-buttons/LEDs and the Murax GPIO port.
- Replaces direct key-to-gpio and gpio-to-LED wiring.
- Per key: synchronisation, debouncing, press/release event detection and a sticky pending flag.
- Per LED: a mode select among GPIO-direct, PWM dimming, blink, and PWM-dimmed blink.

Parameters:
- KEYS, 4, number of key inputs.
- LEDS, 4, number of LED outputs.
- KEY_ACTIVE_LOW, 1, 1 = key pin reads 0 when pressed.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new key level (10 ms at 25 MHz); minimum 2.
- PWM_BITS, 8, width of the PWM counter and duty fields.
- BLINK_DIV, 12500000, cycles per blink half-period (1 Hz at 25 MHz); minimum 1.

Ports:
- io_mainClk, in, 1, sole clock.
- io_resetn, in, 1, reset: synchronous, active-low.
- io_key, in, KEYS, raw asynchronous key pins.
- io_keyState, out, KEYS, debounced level; 1 = pressed. Feeds gpioA read.
- io_keyPress, out, KEYS, one-cycle pulse on a debounced press.
- io_keyRelease, out, KEYS, one-cycle pulse on a debounced release.
- io_keyPending, out, KEYS, sticky press flag.
- io_keyClear, in, KEYS, per-bit clear of io_keyPending.
- io_gpioWrite, in, LEDS, GPIO write value.
- io_gpioWriteEnable, in, LEDS, GPIO output enable.
- io_ledMode, in, 2*LEDS, per-LED mode; LED i uses bits [2i+1:2i].
- io_ledDuty, in, PWM_BITS*LEDS, per-LED duty; LED i uses slice i.
- io_led, out, LEDS, registered LED drive; 1 = lit.

Behaviour:

Reset (io_resetn low at a clock edge):
- Synchronisers load the inactive level.
- Debounce counters, PWM counter, blink prescaler, blink phase, io_keyState, io_keyPress, io_keyRelease, io_keyPending and io_led all go to 0.
- Reset asserted mid-debounce or mid-PWM aborts the operation; no event is emitted.
- First cycle after reset: all outputs 0.

Key path (per key):
- 2-FF synchroniser, then polarity normalisation: pressed = 1.
- Counter cnt:
  - Cleared whenever the synchronised level equals the debounced state.
  - Otherwise increments.
  - When cnt == DEBOUNCE_CYCLES-1 and the level still differs: state takes the new level, cnt clears, and the matching press/release pulse asserts for exactly that one cycle (registered, aligned with the state change).
- A glitch shorter than DEBOUNCE_CYCLES resets cnt; no state change, no pulse.
- Latency from a stable pin change to io_keyState/pulse = 2 + DEBOUNCE_CYCLES cycles.
- io_keyPending:
  - Set on io_keyPress.
  - Cleared on io_keyClear.
  - Press and clear in the same cycle: set wins.
  - Release does not clear it.

LED path:
- Shared free-running PWM counter pwm, PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0.
- pwm_on(i) = (pwm < duty_i).
  - duty 0: never on.
  - duty 2^PWM_BITS-1: on 255 of 256 cycles at default width.
- Shared blink prescaler counts 0..BLINK_DIV-1. On wrap, blink phase toggles; phase starts at 0 (off) after reset.
- Mode encoding:
  - 00: io_gpioWrite[i] & io_gpioWriteEnable[i].
  - 01: pwm_on(i).
  - 10: blink phase.
  - 11: blink phase & pwm_on(i).
- io_led is registered: one cycle of latency from mode/duty/gpio inputs and counters.
- Mode and duty changes take effect immediately; there is no wait for the PWM period boundary.
- Unused key/LED bits do not exist; widths track the parameters exactly.

Decomposition:
- Package karnix_io_pkg holds:
  - LED mode constants LED_MODE_GPIO=2'b00, LED_MODE_PWM=2'b01, LED_MODE_BLINK=2'b10, LED_MODE_BLINK_PWM=2'b11.
  - A clog2 helper for counter widths.
- One sub-module, karnix_key_debounce: single key with synchroniser, counter, state, press/release pulses and pending flag. It is instantiated KEYS times in a generate loop.
- The PWM counter, blink prescaler and LED mux stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, PWM_BITS=4, BLINK_DIV=3, KEY_ACTIVE_LOW=1):
1. Reset: hold io_resetn=0 for 3 cycles with io_key=4'b0000 (all pressed) -> io_keyState, io_keyPress, io_keyPending and io_led all 0. After release of reset, key0 press is recognised: io_keyPress[0] pulses at cycle 6 (2 + 4).
2. Debounce: io_key[1] low for 3 cycles, high for 1, then low for 10 -> no pulse from the 3-cycle glitch. io_keyState[1]=1 and a single io_keyPress[1] pulse exactly 6 cycles after the final falling edge.
3. Pending: press key2 while io_keyClear[2]=1 on the press-pulse cycle -> io_keyPending[2]=1. Clear one cycle later -> 0. Release of key2 -> io_keyRelease[2] pulse, pending stays 0.
4. PWM: io_ledMode[1:0]=01 with duty 4'd5 -> io_led[0] high exactly 5 of every 16 cycles. Duty 0 -> constant 0. Duty 15 -> 15 of 16.
5. Blink and BLINK_PWM: mode 10 -> io_led toggles every 3 cycles, starting off. Mode 11 with duty 8 -> lit only while phase=1 and pwm<8.
6. GPIO mode and reset mid-debounce: mode 00, write=1/enable=0 -> led 0; enable=1 -> led 1 on the next cycle. io_resetn low mid-count (cnt=2) -> no event, state 0 after reset.
